memory_access: RTL and testbench

MEMORY_ACCESS -- requirements
Module: memory_access

---
 rtl/mem_pkg.sv | 23 ++
 rtl/ack_timer.sv | 47 ++++
 rtl/memory_access.sv | 187 ++++++++++++++++++
 tb/tb_memory_access.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// | mem_pkg                                                                 |
// | Shared state encoding and constants for the memory-access stage.        |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HALT   = 2'd2
  } state_t;

  localparam int C_DEFAULT_TIMEOUT = 16;

  // Low address bits that must be zero for a doubleword-aligned access
  localparam int C_ALIGN_BITS = 3;

endpackage

`default_nettype wire

// File: rtl/ack_timer.sv
// ---------------------------------------------------------------------------
// | ack_timer                                                               |
// | Saturating wait counter; done flags the last allowed ACCESS cycle.      |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module ack_timer
  import mem_pkg::*;
#(
  parameter int TIMEOUT = C_DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int C_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [C_W-1:0] C_LAST = C_W'(TIMEOUT - 1);

  logic [C_W-1:0] count_q;
  logic [C_W-1:0] count_d;

  assign done = (count_q == C_LAST);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !done) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/memory_access.sv
// ---------------------------------------------------------------------------
// | memory_access                                                           |
// | Pipeline MEM stage: issues data-memory requests, builds the writeback   |
// | bundle and resolves branches; faults halt the stage until reset.        |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module memory_access
  import mem_pkg::*;
#(
  parameter int N       = 64,
  parameter int TIMEOUT = C_DEFAULT_TIMEOUT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ex_valid,
  output logic         ex_ready,
  input  logic [N-1:0] aluResult_E,
  input  logic [N-1:0] writeData_E,
  input  logic [N-1:0] PCBranch_E,
  input  logic         zero_E,
  input  logic         memRead_E,
  input  logic         memWrite_E,
  input  logic         branch_E,
  input  logic         regWrite_E,
  input  logic         memtoReg_E,
  input  logic [4:0]   rd_E,
  output logic         dm_req,
  output logic         dm_we,
  output logic [N-1:0] dm_addr,
  output logic [N-1:0] dm_wdata,
  input  logic         dm_ack,
  input  logic [N-1:0] dm_rdata,
  output logic         wb_valid,
  output logic [N-1:0] readData_W,
  output logic [N-1:0] aluResult_W,
  output logic [4:0]   rd_W,
  output logic         regWrite_W,
  output logic         memtoReg_W,
  output logic         PCSrc_M,
  output logic [N-1:0] PCBranch_M,
  output logic         err_M
);

  state_t         state_q, state_d;
  logic [N-1:0]   alu_q, alu_d;
  logic [N-1:0]   wdata_q, wdata_d;
  logic [N-1:0]   pcbr_q, pcbr_d;
  logic [N-1:0]   rdata_q, rdata_d;
  logic [4:0]     rd_q, rd_d;
  logic           we_q, we_d;
  logic           regwrite_q, regwrite_d;
  logic           memtoreg_q, memtoreg_d;
  logic           take_q, take_d;
  logic           wb_valid_q, wb_valid_d;
  logic           err_q, err_d;

  logic           w_accept;
  logic           w_is_mem;
  logic           w_misaligned;
  logic           w_enter_access;
  logic           w_timer_done;

  // Held low while reset is asserted so no op is taken during reset
  assign ex_ready       = (state_q == IDLE) && reset;
  assign w_accept       = ex_valid && ex_ready;
  assign w_is_mem       = memRead_E || memWrite_E;
  assign w_misaligned   = (aluResult_E[C_ALIGN_BITS-1:0] != '0);
  assign w_enter_access = w_accept && w_is_mem && !w_misaligned;

  ack_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_ack_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_enter_access),
    .enable ((state_q == ACCESS) && !dm_ack),
    .done   (w_timer_done)
  );

  always_comb begin
    state_d    = state_q;
    alu_d      = alu_q;
    wdata_d    = wdata_q;
    pcbr_d     = pcbr_q;
    rdata_d    = rdata_q;
    rd_d       = rd_q;
    we_d       = we_q;
    regwrite_d = regwrite_q;
    memtoreg_d = memtoreg_q;
    take_d     = take_q;
    wb_valid_d = 1'b0;
    err_d      = err_q;

    case (state_q)
      IDLE: begin
        if (w_accept) begin
          alu_d      = aluResult_E;
          wdata_d    = writeData_E;
          pcbr_d     = PCBranch_E;
          rd_d       = rd_E;
          we_d       = memWrite_E;
          regwrite_d = regWrite_E;
          memtoreg_d = memtoReg_E;
          take_d     = branch_E && zero_E;
          if (!w_is_mem) begin
            wb_valid_d = 1'b1;
          end else if (w_misaligned) begin
            regwrite_d = 1'b0;
            take_d     = 1'b0;
            err_d      = 1'b1;
            state_d    = HALT;
          end else begin
            state_d    = ACCESS;
          end
        end
      end
      ACCESS: begin
        // An ack on the final wait cycle still wins over the timeout
        if (dm_ack) begin
          rdata_d    = dm_rdata;
          wb_valid_d = 1'b1;
          state_d    = IDLE;
        end else if (w_timer_done) begin
          regwrite_d = 1'b0;
          take_d     = 1'b0;
          err_d      = 1'b1;
          state_d    = HALT;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      alu_q      <= '0;
      wdata_q    <= '0;
      pcbr_q     <= '0;
      rdata_q    <= '0;
      rd_q       <= '0;
      we_q       <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      take_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_q      <= alu_d;
      wdata_q    <= wdata_d;
      pcbr_q     <= pcbr_d;
      rdata_q    <= rdata_d;
      rd_q       <= rd_d;
      we_q       <= we_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      take_q     <= take_d;
      wb_valid_q <= wb_valid_d;
      err_q      <= err_d;
    end
  end

  assign dm_req      = (state_q == ACCESS);
  assign dm_we       = we_q && (state_q == ACCESS);
  assign dm_addr     = alu_q;
  assign dm_wdata    = wdata_q;
  assign wb_valid    = wb_valid_q;
  assign readData_W  = rdata_q;
  assign aluResult_W = alu_q;
  assign rd_W        = rd_q;
  assign regWrite_W  = regwrite_q;
  assign memtoReg_W  = memtoreg_q;
  assign PCSrc_M     = wb_valid_q && take_q;
  assign PCBranch_M  = pcbr_q;
  assign err_M       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_memory_access.sv
// ---------------------------------------------------------------------------
// | tb_memory_access                                                        |
// | Directed self-checking bench for memory_access.                         |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_memory_access;

  localparam int N = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         ex_valid;
  logic         ex_ready;
  logic [N-1:0] aluResult_E, writeData_E, PCBranch_E;
  logic         zero_E, memRead_E, memWrite_E, branch_E, regWrite_E, memtoReg_E;
  logic [4:0]   rd_E;
  logic         dm_req, dm_we;
  logic [N-1:0] dm_addr, dm_wdata;
  logic         dm_ack;
  logic [N-1:0] dm_rdata;
  logic         wb_valid;
  logic [N-1:0] readData_W, aluResult_W;
  logic [4:0]   rd_W;
  logic         regWrite_W, memtoReg_W, PCSrc_M;
  logic [N-1:0] PCBranch_M;
  logic         err_M;

  int checks = 0;
  int errors = 0;

  memory_access #(.N(N), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .aluResult_E(aluResult_E), .writeData_E(writeData_E), .PCBranch_E(PCBranch_E),
    .zero_E(zero_E), .memRead_E(memRead_E), .memWrite_E(memWrite_E),
    .branch_E(branch_E), .regWrite_E(regWrite_E), .memtoReg_E(memtoReg_E),
    .rd_E(rd_E), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .wb_valid(wb_valid), .readData_W(readData_W), .aluResult_W(aluResult_W),
    .rd_W(rd_W), .regWrite_W(regWrite_W), .memtoReg_W(memtoReg_W),
    .PCSrc_M(PCSrc_M), .PCBranch_M(PCBranch_M), .err_M(err_M)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_ex();
    ex_valid    = 1'b0;
    aluResult_E = '0;
    writeData_E = '0;
    PCBranch_E  = '0;
    zero_E      = 1'b0;
    memRead_E   = 1'b0;
    memWrite_E  = 1'b0;
    branch_E    = 1'b0;
    regWrite_E  = 1'b0;
    memtoReg_E  = 1'b0;
    rd_E        = '0;
  endtask

  initial begin
    clear_ex();
    reset    = 1'b0;
    dm_ack   = 1'b0;
    dm_rdata = '0;

    // Reset state
    tick(); tick();
    chk("rst_ex_ready", N'(ex_ready), 0);
    chk("rst_dm_req", N'(dm_req), 0);
    chk("rst_wb_valid", N'(wb_valid), 0);
    chk("rst_err", N'(err_M), 0);
    reset = 1'b1;
    tick();
    chk("rel_ex_ready", N'(ex_ready), 1);

    // Non-memory op
    ex_valid = 1'b1; aluResult_E = 64'h40; regWrite_E = 1'b1; rd_E = 5'd3;
    tick();
    clear_ex();
    chk("nm_wb_valid", N'(wb_valid), 1);
    chk("nm_alu", aluResult_W, 64'h40);
    chk("nm_rd", N'(rd_W), 3);
    chk("nm_regwrite", N'(regWrite_W), 1);
    chk("nm_dm_req", N'(dm_req), 0);
    chk("nm_ex_ready", N'(ex_ready), 1);
    tick();
    chk("nm_wb_pulse", N'(wb_valid), 0);

    // Branch taken then not taken
    ex_valid = 1'b1; branch_E = 1'b1; zero_E = 1'b1; PCBranch_E = 64'h200;
    tick();
    chk("br_pcsrc", N'(PCSrc_M), 1);
    chk("br_target", PCBranch_M, 64'h200);
    zero_E = 1'b0;
    tick();
    clear_ex();
    chk("br_nz_pcsrc", N'(PCSrc_M), 0);
    chk("br_nz_wb", N'(wb_valid), 1);
    tick();
    chk("br_pulse", N'(PCSrc_M), 0);

    // Load at 0x100, ack on third ACCESS cycle
    ex_valid = 1'b1; memRead_E = 1'b1; aluResult_E = 64'h100;
    regWrite_E = 1'b1; memtoReg_E = 1'b1; rd_E = 5'd5;
    tick();
    clear_ex();
    chk("ld_req1", N'(dm_req), 1);
    chk("ld_addr", dm_addr, 64'h100);
    chk("ld_we", N'(dm_we), 0);
    chk("ld_rdy1", N'(ex_ready), 0);
    tick();
    chk("ld_req2", N'(dm_req), 1);
    chk("ld_rdy2", N'(ex_ready), 0);
    tick();
    chk("ld_req3", N'(dm_req), 1);
    chk("ld_rdy3", N'(ex_ready), 0);
    dm_ack = 1'b1; dm_rdata = 64'h0000_0000_DEAD_BEEF;
    tick();
    dm_ack = 1'b0; dm_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    chk("ld_req_off", N'(dm_req), 0);
    chk("ld_wb", N'(wb_valid), 1);
    chk("ld_data", readData_W, 64'h0000_0000_DEAD_BEEF);
    chk("ld_m2r", N'(memtoReg_W), 1);
    chk("ld_rd", N'(rd_W), 5);
    chk("ld_err", N'(err_M), 0);

    // Store at 0x8
    ex_valid = 1'b1; memWrite_E = 1'b1; aluResult_E = 64'h8; writeData_E = 64'h55;
    tick();
    clear_ex();
    chk("st_we1", N'(dm_we), 1);
    chk("st_wdata1", dm_wdata, 64'h55);
    chk("st_addr", dm_addr, 64'h8);
    tick();
    chk("st_we2", N'(dm_we), 1);
    chk("st_wdata2", dm_wdata, 64'h55);
    dm_ack = 1'b1;
    tick();
    dm_ack = 1'b0;
    chk("st_wb", N'(wb_valid), 1);
    chk("st_regwrite", N'(regWrite_W), 0);
    chk("st_req_off", N'(dm_req), 0);

    // Read+write treated as write; minimum latency
    ex_valid = 1'b1; memRead_E = 1'b1; memWrite_E = 1'b1; aluResult_E = 64'h10;
    tick();
    clear_ex();
    chk("rw_we", N'(dm_we), 1);
    dm_ack = 1'b1;
    tick();
    chk("rw_wb", N'(wb_valid), 1);

    // Ack in IDLE is ignored
    tick();
    chk("idle_ack_wb", N'(wb_valid), 0);
    dm_ack = 1'b0;

    // Ack on 16th ACCESS cycle completes without error
    ex_valid = 1'b1; memRead_E = 1'b1; aluResult_E = 64'h20;
    tick();
    clear_ex();
    repeat (15) tick();
    chk("late_req", N'(dm_req), 1);
    dm_ack = 1'b1; dm_rdata = 64'h1234;
    tick();
    dm_ack = 1'b0;
    chk("late_wb", N'(wb_valid), 1);
    chk("late_err", N'(err_M), 0);
    chk("late_data", readData_W, 64'h1234);

    // Reset mid-wait abandons the access
    ex_valid = 1'b1; memRead_E = 1'b1; aluResult_E = 64'h30; regWrite_E = 1'b1;
    tick();
    clear_ex();
    tick();
    chk("ra_req", N'(dm_req), 1);
    reset = 1'b0;
    tick();
    chk("ra_req_off", N'(dm_req), 0);
    chk("ra_wb", N'(wb_valid), 0);
    chk("ra_rdy_rst", N'(ex_ready), 0);
    reset = 1'b1;
    #1;
    chk("ra_rdy_rel", N'(ex_ready), 1);
    tick();
    chk("ra_wb_after", N'(wb_valid), 0);

    // Timeout after 16 cycles without ack
    ex_valid = 1'b1; memRead_E = 1'b1; aluResult_E = 64'h40;
    regWrite_E = 1'b1; branch_E = 1'b1; zero_E = 1'b1;
    tick();
    clear_ex();
    repeat (15) tick();
    chk("to_req16", N'(dm_req), 1);
    chk("to_err16", N'(err_M), 0);
    tick();
    chk("to_err", N'(err_M), 1);
    chk("to_req_off", N'(dm_req), 0);
    chk("to_rdy", N'(ex_ready), 0);
    chk("to_wb", N'(wb_valid), 0);
    chk("to_pcsrc", N'(PCSrc_M), 0);
    chk("to_regwrite", N'(regWrite_W), 0);
    dm_ack = 1'b1;
    tick();
    dm_ack = 1'b0;
    chk("halt_ack_wb", N'(wb_valid), 0);
    reset = 1'b0;
    tick();
    chk("to_err_clr", N'(err_M), 0);
    reset = 1'b1;
    tick();

    // Misaligned load at 0x104
    ex_valid = 1'b1; memRead_E = 1'b1; aluResult_E = 64'h104; regWrite_E = 1'b1;
    tick();
    chk("mis_err", N'(err_M), 1);
    chk("mis_req", N'(dm_req), 0);
    chk("mis_rdy", N'(ex_ready), 0);
    chk("mis_wb", N'(wb_valid), 0);
    chk("mis_regwrite", N'(regWrite_W), 0);
    tick();
    chk("mis_rdy_hold", N'(ex_ready), 0);
    chk("mis_req_hold", N'(dm_req), 0);
    clear_ex();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
